// File: rtl/neopixel_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_frame_loader
// Brief    : Snapshots a frame of 3-bit colour codes, maps each through a
//            fixed palette to 8-bit R/G/B, issues one load per pixel to the
//            Neopixel controller, then a single go. Tracks the controller
//            ready handshake, reports busy/done and queues one pending update.
// Options  : NEOPIXEL_DIM_EN - adds a 'dim' input that drops every lit
//            palette channel to LEVEL>>2.
// Revision : 1.0 - initial release
// ============================================================================
module neopixel_frame_loader #(
    parameter int          NUM_PIXELS = 8,
    parameter int          PIX_W      = $clog2(NUM_PIXELS),
    parameter logic [7:0]  LEVEL      = 8'h20
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [3*NUM_PIXELS-1:0] colors,
    input  logic                    update,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              red,
    output logic [7:0]              green,
    output logic [7:0]              blue,
    output logic [PIX_W-1:0]        pixel,
    output logic                    load,
    output logic                    go,
    input  logic                    ready
`ifdef NEOPIXEL_DIM_EN
    ,
    input  logic                    dim
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_GO        = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam logic [PIX_W-1:0] c_LAST_IDX  = PIX_W'(NUM_PIXELS - 1);
    localparam logic [7:0]       c_LEVEL_DIM = LEVEL >> 2;

    logic [2:0]                       r_state;
    logic [PIX_W-1:0]                 r_idx;
    logic [NUM_PIXELS-1:0][2:0]       r_frame;
    logic                             r_pending;

    logic                             w_restart;
    logic [2:0]                       w_code;
    logic [7:0]                       w_level;

    // A refresh finishing with a queued or simultaneous request restarts at once
    assign w_restart = (r_state == S_WAIT_DONE) && ready && (r_pending || update);
    assign w_code    = r_frame[r_idx];

`ifdef NEOPIXEL_DIM_EN
    assign w_level = dim ? c_LEVEL_DIM : LEVEL;
`else
    assign w_level = LEVEL;
`endif

    // Main sequencer: accept, per-pixel loads, go, then wait out the refresh
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (update) begin
                        r_frame <= colors;
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_GO;
                        end else begin
                            r_idx <= r_idx + PIX_W'(1);
                        end
                    end
                end
                S_GO: begin
                    if (ready) begin
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // Controller drops ready once it starts shifting the strip
                    if (!ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (ready) begin
                        if (w_restart) begin
                            r_frame <= colors;
                            r_idx   <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Single-entry request queue: any number of updates while busy coalesce
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (w_restart) begin
            r_pending <= 1'b0;
        end else if ((r_state != S_IDLE) && update) begin
            r_pending <= 1'b1;
        end
    end

    // Controller-facing outputs decoded from registered state plus ready
    always_comb begin
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_WAIT_DONE) && ready;
        load  = 1'b0;
        go    = 1'b0;
        pixel = '0;
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
        if (r_state == S_GO) begin
            go = ready;
        end
        if (r_state == S_LOAD) begin
            load  = ready;
            pixel = r_idx;
            case (w_code)
                3'd1: begin red = w_level; end
                3'd2: begin green = w_level; end
                3'd3: begin blue = w_level; end
                3'd4: begin red = w_level; green = w_level; end
                3'd5: begin green = w_level; blue = w_level; end
                3'd6: begin red = w_level; blue = w_level; end
                3'd7: begin red = w_level; green = w_level; blue = w_level; end
                default: begin end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neopixel_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopixel_frame_loader
// Brief    : Directed self-checking bench for neopixel_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopixel_frame_loader;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic [23:0] colors;
    logic        update;
    logic        ready;
    logic        busy, done, load, go;
    logic [7:0]  red, green, blue;
    logic [2:0]  pixel;
    logic [23:0] w_rgb;
`ifdef NEOPIXEL_DIM_EN
    logic        dim;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    assign w_rgb = {red, green, blue};

    neopixel_frame_loader dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .colors   (colors),
        .update   (update),
        .busy     (busy),
        .done     (done),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .pixel    (pixel),
        .load     (load),
        .go       (go),
        .ready    (ready)
`ifdef NEOPIXEL_DIM_EN
        ,
        .dim      (dim)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the drive point of the next cycle (1 time unit after posedge)
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before next edge)
    task automatic settle();
        #2;
    endtask

    // Hand-written palette at LEVEL = 0x20
    function automatic logic [23:0] pal(input logic [2:0] code);
        case (code)
            3'd0: pal = 24'h000000;
            3'd1: pal = 24'h200000;
            3'd2: pal = 24'h002000;
            3'd3: pal = 24'h000020;
            3'd4: pal = 24'h202000;
            3'd5: pal = 24'h002020;
            3'd6: pal = 24'h200020;
            default: pal = 24'h202020;
        endcase
    endfunction

    // Called at the drive point of the first LOAD cycle; ends after the go edge
    task automatic run_frame(input logic [23:0] cols, input int stall_at, input int stall_len);
        logic [23:0] exp_rgb;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    settle();
                    check("stall_load", load, 0);
                    check("stall_pixel", pixel, i);
                    step();
                end
                ready = 1'b1;
            end
            exp_rgb = pal(cols[3*i +: 3]);
`ifdef NEOPIXEL_DIM_EN
            if (cols[3*i +: 3] == 3'd7) begin
                dim = 1'b1;
                exp_rgb = 24'h080808;
            end
`endif
            settle();
            check("load", load, 1);
            check("pixel", pixel, i);
            check("rgb", w_rgb, exp_rgb);
            check("go_in_load", go, 0);
            check("busy_load", busy, 1);
            step();
`ifdef NEOPIXEL_DIM_EN
            dim = 1'b0;
`endif
        end
        settle();
        check("go", go, 1);
        check("load_in_go", load, 0);
        check("rgb_in_go", w_rgb, 0);
        step();
    endtask

    // Called at the drive point after go; ends after the done edge
    task automatic ack_done(input int gap);
        int act;
        act = 0;
        settle();
        check("ack_go_low", go, 0);
        step();
        ready = 1'b0;
        for (int c = 0; c < gap; c++) begin
            settle();
            act += int'(done) + int'(load) + int'(go) + int'(!busy);
            step();
        end
        check("wait_quiet", act, 0);
        ready = 1'b1;
        settle();
        check("done", done, 1);
        check("busy_at_done", busy, 1);
        step();
    endtask

    initial begin
        int act;
        reset_n = 1'b0;
        ready   = 1'b1;
        update  = 1'b0;
        colors  = 24'h0;
`ifdef NEOPIXEL_DIM_EN
        dim     = 1'b0;
`endif
        step();
        step();
        settle();
        check("rst_busy", busy, 0);
        check("rst_loadgo", {load, go, done}, 0);
        check("rst_pixel_rgb", {pixel, w_rgb}, 0);
        reset_n = 1'b1;
        step();

        // Full frame, every palette code, snapshot protected against colour changes
        colors = 24'o76543210;
        update = 1'b1;
        step();
        update = 1'b0;
        colors = 24'o0;
        run_frame(24'o76543210, -1, 0);
        ack_done(2500);
        settle();
        check("busy_after_done", busy, 0);
        check("done_once", done, 0);
        step();

        // Stall while pixel 3 is pending
        colors = 24'o01234567;
        update = 1'b1;
        step();
        update = 1'b0;
        run_frame(24'o01234567, 3, 5);
        ack_done(10);
        settle();
        check("busy_idle2", busy, 0);
        step();

        // Three updates during WAIT_DONE coalesce into one extra frame
        colors = 24'o76543210;
        update = 1'b1;
        step();
        update = 1'b0;
        run_frame(24'o76543210, -1, 0);
        settle();
        step();
        ready  = 1'b0;
        colors = 24'o11111111;
        for (int c = 0; c < 8; c++) begin
            update = (c == 2 || c == 4 || c == 6);
            step();
        end
        update = 1'b0;
        ready  = 1'b1;
        settle();
        check("done_before_extra", done, 1);
        step();
        run_frame(24'o11111111, -1, 0);
        ack_done(5);
        act = 0;
        for (int c = 0; c < 20; c++) begin
            settle();
            act += int'(busy) + int'(load) + int'(go) + int'(done);
            step();
        end
        check("no_second_extra", act, 0);

        // Asynchronous reset in the middle of LOAD
        colors = 24'o77777777;
        update = 1'b1;
        step();
        update = 1'b0;
        step();
        step();
        settle();
        check("pre_reset_load", load, 1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_strobes", {load, go, done}, 0);
        check("arst_pixel_rgb", {pixel, w_rgb}, 0);
        step();
        step();
        reset_n = 1'b1;
        act = 0;
        for (int c = 0; c < 20; c++) begin
            settle();
            act += int'(busy) + int'(load) + int'(go) + int'(done);
            step();
        end
        check("post_reset_quiet", act, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
